// File: rtl/context_scheduler.sv
// Round-robin time-slice scheduler driving a save/restore context switcher.
// Optional busy timeout with sticky ctx_fault: define CTX_TIMEOUT_EN.
module context_scheduler #(
    parameter int QUANTUM = 1024,
    parameter int TIMEOUT = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] prog_active,
    input  logic        yield_req,
    input  logic        busy,
    output logic [3:0]  cur_prog,
    output logic        save_trigger,
    output logic        restore_trigger,
    output logic        cpu_stall,
    output logic        switch_done,
    output logic [15:0] quantum_left,
    output logic        ctx_fault
);

    if (QUANTUM < 1 || QUANTUM > 65535) begin : g_bad_quantum
        $error("QUANTUM out of range");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65536) begin : g_bad_timeout
        $error("TIMEOUT out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        SELECT,
        SAVE,
        GAP,
        RESTORE,
        RESUME
    } state_t;

    localparam logic [15:0] QLOAD = 16'(QUANTUM);

    state_t      state;
    state_t      state_n;
    logic [3:0]  next_prog;
    logic        first;
    logic        found;
    logic [3:0]  pick;
    logic [3:0]  idx;
    logic        tmo_hit;
    logic        in_xfer;

    assign in_xfer = (state == SAVE) || (state == RESTORE);

    // Scan slots after cur_prog, wrapping; cur_prog itself is never chosen.
    always_comb begin
        found = 1'b0;
        pick  = cur_prog;
        idx   = cur_prog;
        for (int k = 1; k < 16; k++) begin
            idx = cur_prog + 4'(k);
            if (!found && prog_active[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

`ifdef CTX_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tmo_cnt;

    always_ff @(posedge clock) begin
        if (reset || state_n != state) begin
            tmo_cnt <= '0;
        end else if (in_xfer) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign tmo_hit = in_xfer && busy && (tmo_cnt == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (enable) state_n = RUN;
            end
            RUN: begin
                if (!enable)
                    state_n = IDLE;
                else if (yield_req || quantum_left == 16'd1)
                    state_n = SELECT;
            end
            SELECT: begin
                state_n = found ? SAVE : RUN;
            end
            SAVE: begin
                if (tmo_hit)
                    state_n = IDLE;
                else if (!first && !busy)
                    state_n = GAP;
            end
            GAP: begin
                state_n = RESTORE;
            end
            RESTORE: begin
                if (tmo_hit)
                    state_n = IDLE;
                else if (!first && !busy)
                    state_n = RESUME;
            end
            RESUME: begin
                state_n = RUN;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cur_prog     <= '0;
            next_prog    <= '0;
            quantum_left <= QLOAD;
            first        <= 1'b0;
            ctx_fault    <= 1'b0;
        end else begin
            state <= state_n;
            // First cycle of a transfer ignores busy: switcher has not seen it yet.
            first <= (state_n == SAVE && state != SAVE) ||
                     (state_n == RESTORE && state != RESTORE);
            if (tmo_hit) ctx_fault <= 1'b1;
            case (state)
                IDLE: begin
                    if (enable) quantum_left <= QLOAD;
                end
                RUN: begin
                    quantum_left <= quantum_left - 16'd1;
                end
                SELECT: begin
                    if (found)
                        next_prog <= pick;
                    else
                        quantum_left <= QLOAD;
                end
                GAP: begin
                    cur_prog <= next_prog;
                end
                RESUME: begin
                    quantum_left <= QLOAD;
                end
                default: ;
            endcase
        end
    end

    assign save_trigger    = (state == SAVE);
    assign restore_trigger = (state == RESTORE);
    assign cpu_stall       = (state != RUN);
    assign switch_done     = (state == RESUME);

endmodule

// File: tb/tb_context_scheduler.sv
// Directed bench for context_scheduler with a behavioural switcher busy model.
// Timeout checks apply when CTX_TIMEOUT_EN is defined.
module tb_context_scheduler;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [15:0] prog_active;
    logic        yield_req;
    logic        busy;
    logic [3:0]  cur_prog;
    logic        save_trigger;
    logic        restore_trigger;
    logic        cpu_stall;
    logic        switch_done;
    logic [15:0] quantum_left;
    logic        ctx_fault;

    int n_tests = 0;
    int n_fail  = 0;
    int blen    = 35;
    bit stuck   = 0;
    int bcnt    = 0;
    logic trig;

    context_scheduler #(
        .QUANTUM(8),
        .TIMEOUT(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .prog_active(prog_active),
        .yield_req(yield_req),
        .busy(busy),
        .cur_prog(cur_prog),
        .save_trigger(save_trigger),
        .restore_trigger(restore_trigger),
        .cpu_stall(cpu_stall),
        .switch_done(switch_done),
        .quantum_left(quantum_left),
        .ctx_fault(ctx_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Switcher model: busy for blen cycles after a trigger rises.
    assign trig = save_trigger | restore_trigger;
    always @(posedge clock) bcnt <= trig ? bcnt + 1 : 0;
    assign busy = trig && (stuck || bcnt < blen);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic count_run(output int n);
        n = 0;
        while (!cpu_stall && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic yield_now();
        yield_req = 1'b1;
        step();
        yield_req = 1'b0;
    endtask

    task automatic do_switch(output int sv, output int gp, output int rs,
                             output int dn, output int ov);
        bit seen_s = 0;
        bit seen_r = 0;
        int g = 0;
        sv = 0; gp = 0; rs = 0; dn = 0; ov = 0;
        while (cpu_stall && g < 400) begin
            if (save_trigger && restore_trigger) ov++;
            if (save_trigger) begin sv++; seen_s = 1; end
            if (restore_trigger) begin rs++; seen_r = 1; end
            if (switch_done) dn++;
            if (seen_s && !seen_r && !trig) gp++;
            g++;
            step();
        end
        chk("switch_bound", 32'(g < 400), 1);
    endtask

    initial begin
        int n, sv, gp, rs, dn, ov;
        reset = 1'b1;
        enable = 1'b0;
        prog_active = 16'h0003;
        yield_req = 1'b0;
        step(2);
        chk("rst_stall", cpu_stall, 1);
        chk("rst_prog", cur_prog, 0);
        chk("rst_ql", quantum_left, 8);
        chk("rst_trig", trig, 0);
        chk("rst_done", switch_done, 0);
        chk("rst_fault", ctx_fault, 0);

        // 1: expiry switch 0 -> 1 with 35-cycle busy
        reset = 1'b0;
        enable = 1'b1;
        step();
        chk("t1_ql_start", quantum_left, 8);
        count_run(n);
        chk("t1_run_cycles", n, 8);
        do_switch(sv, gp, rs, dn, ov);
        chk("t1_save_cyc", sv, 36);
        chk("t1_gap_cyc", gp, 1);
        chk("t1_rest_cyc", rs, 36);
        chk("t1_done", dn, 1);
        chk("t1_overlap", ov, 0);
        chk("t1_prog", cur_prog, 1);
        chk("t1_ql", quantum_left, 8);

        // 2: yield from 1 wraps to 0, then 0 -> 15 -> 0 with 8001
        blen = 3;
        step(2);
        yield_now();
        do_switch(sv, gp, rs, dn, ov);
        chk("t2_prog_a", cur_prog, 0);
        chk("t2_save_cyc", sv, 4);
        prog_active = 16'h8001;
        step();
        yield_now();
        do_switch(sv, gp, rs, dn, ov);
        chk("t2_prog_b", cur_prog, 15);
        chk("t2_done", dn, 1);
        yield_now();
        do_switch(sv, gp, rs, dn, ov);
        chk("t2_prog_wrap", cur_prog, 0);

        // 3: only current slot active -> no switch
        prog_active = 16'h0001;
        count_run(n);
        chk("t3_run_cycles", n, 8);
        chk("t3_sel_trig", trig, 0);
        chk("t3_sel_done", switch_done, 0);
        step();
        chk("t3_stall", cpu_stall, 0);
        chk("t3_ql", quantum_left, 8);
        chk("t3_trig", trig, 0);
        chk("t3_prog", cur_prog, 0);

        // 4: yield coincides with expiry -> one switch
        prog_active = 16'h0003;
        step(7);
        chk("t4_ql1", quantum_left, 1);
        yield_now();
        do_switch(sv, gp, rs, dn, ov);
        chk("t4_save_cyc", sv, 4);
        chk("t4_rest_cyc", rs, 4);
        chk("t4_done", dn, 1);
        chk("t4_prog", cur_prog, 1);
        step(3);
        chk("t4_ql_after", quantum_left, 5);
        chk("t4_no_second", 32'({cpu_stall, trig}), 0);

        // 5: reset 10 cycles into SAVE
        blen = 35;
        yield_now();
        step();
        step(10);
        chk("t5_in_save", save_trigger, 1);
        reset = 1'b1;
        step();
        chk("t5_trig", trig, 0);
        chk("t5_stall", cpu_stall, 1);
        chk("t5_prog", cur_prog, 0);
        chk("t5_ql", quantum_left, 8);
        reset = 1'b0;
        step();
        chk("t5_rerun", cpu_stall, 0);

        // 6: busy stuck high during SAVE
        stuck = 1;
        yield_now();
        step();
        n = 0;
        while (save_trigger && n < 40) begin
            n++;
            step();
        end
`ifdef CTX_TIMEOUT_EN
        chk("t6_save_len", n, 16);
        chk("t6_fault", ctx_fault, 1);
        chk("t6_stall", cpu_stall, 1);
        chk("t6_trig", trig, 0);
        stuck = 0;
        step(2);
        chk("t6_sticky", ctx_fault, 1);
`else
        chk("t6_save_len", n, 40);
        chk("t6_fault", ctx_fault, 0);
        chk("t6_still_save", save_trigger, 1);
        stuck = 0;
        do_switch(sv, gp, rs, dn, ov);
        chk("t6_done", dn, 1);
        chk("t6_prog", cur_prog, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
